data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter that shares the single-port `data_memory` between port 0 (CPU load/store stage) and port 1 (DMA/program loader). It owns the memory's `address`, `write_data`, `mem_read` and `mem_write` inputs and returns captured `read_data` to the winning port with a valid strobe. Ownership is held for bounded bursts so that neither port starves the other.

## Interface
- `ADDR_W`, 16, address width; matches `data_memory` address.
- `DATA_W`, 16, data width.
- `MAX_BURST`, 4, beats a port may hold ownership while the other port waits; legal range 1..255.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held until acked.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while req high.
- `addr0` / `addr1`  in  ADDR_W  access address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  beat accepted this cycle; combinational from owner state and req.
- `rdata0` / `rdata1`  out  DATA_W  registered read data.
- `rvalid0` / `rvalid1`  out  1  one-cycle strobe; rdataN valid.
- `mem_address`  out  ADDR_W  to data_memory `address`.
- `mem_write_data`  out  DATA_W  to data_memory `write_data`.
- `mem_read` / `mem_write`  out  1  to data_memory.
- `mem_read_data`  in  DATA_W  from data_memory `read_data` (combinational read).

## Operation
- States: IDLE, OWN0, OWN1. Reset state IDLE. Beat counter `beats` is reset to 0 and cleared on every ownership change.
- `ackN = (state == OWNN) & reqN`. Ack is never asserted in IDLE.
- When ackN is high, the memory is driven from port N: `mem_address = addrN`, `mem_write_data = wdataN`, `mem_write = weN`, `mem_read = ~weN`. When no ack is high, all mem outputs are 0.
- Write: commits in memory at the edge that ends the ack cycle.
- Read: `mem_read_data` is captured into rdataN at the edge that ends the ack cycle. rvalidN is high for the following cycle only. rdataN holds its value until the next read by port N.
- IDLE: if exactly one request is high, go to that port's OWN state. If both are high, resolve the tie according to Configuration. If neither is high, stay in IDLE.
- OWNn, evaluated each cycle:
  - `reqN` low: go to OWN(other) if the other port is requesting, else IDLE.
  - `reqN` high and the other port is requesting: increment `beats`. When `beats == MAX_BURST-1` on an acked beat, switch to OWN(other) at that edge.
  - `reqN` high and the other port is idle: stay; `beats` is held at 0.
- Ownership switches directly between OWN0 and OWN1. There is no IDLE bubble.
- `last` register records the most recently granted port. Its reset value is 1, so port 0 wins the first tie.

## Timing
- Reset values: all ack, rvalid and mem_* outputs are 0; rdata0 and rdata1 are 0; state IDLE; `beats` 0; `last` 1.
- Request from IDLE: ack no earlier than 1 cycle after req rises (arbitration cycle).
- Request while already owner: ack in the same cycle, one beat per cycle.
- Read latency: rvalid 1 cycle after ack.
- Ownership handover: the new owner's first ack occurs in the cycle after the old owner's last ack.
- Requester dropping req: its ack falls combinationally in the same cycle.
- Reset mid-operation: mem_write and mem_read fall immediately on rst_n low. A write in flight at that edge is not guaranteed to commit. Pending rvalid is cleared.
- Changes to addr, we or wdata while req is high and ack is low are permitted. The value sampled is the one present in the ack cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - IDLE ties go to the port that is not `last`.
  - MAX_BURST preemption applies to both ports.
- `ARB_ROUND_ROBIN_EN` undefined:
  - IDLE ties always go to port 0.
  - Port 0 is never preempted; only OWN1 is subject to MAX_BURST.
  - Port 1 is served only when port 0 releases its request.

## Test plan
- Reset: hold rst_n low with req0=req1=1 -> all acks, rvalids and mem_* outputs are 0. Release reset -> ack0 goes high one cycle later.
- Port 0 writes addr 0..29 with data = addr, then reads addr 0..29 -> rdata0 equals addr, with rvalid0 one cycle after each ack0. Port 1 stays idle throughout.
- Both ports burst-write 8 beats each with MAX_BURST=4, round-robin enabled -> grant pattern 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 with no idle cycles. Port 1 then reads back its data (port0 data 0x1000+i, port1 data 0x2000+i) with correct values.
- Fixed priority (macro undefined): req0 held for 10 beats while req1 waits -> ack1 stays 0 until req0 drops, then ack1 rises on the next cycle.
- Port 1 owns; req1 drops mid-burst while req0 is high -> ack1 falls the same cycle and ack0 rises the next cycle. A read of addr 5 (data 0x0005) issued on the last port 1 beat returns rvalid1 with rdata1=0x0005.
- Assert rst_n low during a port 0 write to addr 7 (data 0xBEEF) -> mem_write is 0 immediately. After reset the arbiter is in IDLE and rvalid0=rvalid1=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port burst-bounded arbiter for the single-port data_memory (optional ARB_ROUND_ROBIN_EN)
module data_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [7:0] LIM = 8'(MAX_BURST - 1);
  state_t state, state_nx;
  logic [7:0] beats, beats_nx;
  logic last, last_nx;
  logic tie1, pre0;
`ifdef ARB_ROUND_ROBIN_EN
  assign tie1 = ~last;
  assign pre0 = 1'b1;
`else
  assign tie1 = 1'b0;
  assign pre0 = 1'b0;
`endif
  // state, burst counter and last-grant registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      beats <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      beats <= beats_nx;
      last  <= last_nx;
    end
  // next owner: bounded bursts while the other port waits, direct handover
  always_comb begin
    state_nx = state;
    beats_nx = beats;
    last_nx  = last;
    case (state)
      IDLE: state_nx = (req0 & ~(req1 & tie1)) ? OWN0 : req1 ? OWN1 : IDLE;
      OWN0:
        if (!req0) state_nx = req1 ? OWN1 : IDLE;
        else if (req1 & pre0) begin
          if (beats == LIM) state_nx = OWN1;
          else beats_nx = beats + 8'd1;
        end else beats_nx = '0;
      OWN1:
        if (!req1) state_nx = req0 ? OWN0 : IDLE;
        else if (req0) begin
          if (beats == LIM) state_nx = OWN0;
          else beats_nx = beats + 8'd1;
        end else beats_nx = '0;
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) begin
      beats_nx = '0;
      last_nx  = (state_nx == OWN0) ? 1'b0 : (state_nx == OWN1) ? 1'b1 : last;
    end
  end
  // acks and memory steering follow the current owner combinationally
  always_comb begin
    ack0           = (state == OWN0) & req0;
    ack1           = (state == OWN1) & req1;
    mem_address    = ack0 ? addr0 : ack1 ? addr1 : '0;
    mem_write_data = ack0 ? wdata0 : ack1 ? wdata1 : '0;
    mem_write      = ack0 ? we0 : ack1 ? we1 : 1'b0;
    mem_read       = ack0 ? ~we0 : ack1 ? ~we1 : 1'b0;
  end
  // capture read data at the end of each acked read beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= ack0 & ~we0;
      rvalid1 <= ack1 & ~we1;
      if (ack0 & ~we0) rdata0 <= mem_read_data;
      if (ack1 & ~we1) rdata1 <= mem_read_data;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of data_mem_arbiter against a small memory model
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic ack0, ack1, rvalid0, rvalid1, mem_read, mem_write;
  logic [15:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;
  logic [15:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always @(posedge clk) if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    @(negedge clk);
    while (!(p == 0 ? ack0 : ack1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_ack_wait", 32'(n < 20), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c0, c1, n, idles, cyc;
    logic [15:0] g, pat;
    logic [5:0] pre;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_mem_ctl", {mem_read, mem_write}, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("arb_cycle_ack0", ack0, 0);
    @(negedge clk);
    check("first_tie_ack0", ack0, 1);
    check("first_tie_ack1", ack1, 0);
    @(posedge clk); #1;
    idle_all();

    for (int i = 0; i < 30; i++) beat(0, 1'b1, 16'(i), 16'(i));
    for (int i = 0; i < 30; i++) begin
      beat(0, 1'b0, 16'(i), 16'h0);
      check("rd0_valid", rvalid0, 1);
      check("rd0_data", rdata0, 32'(i));
    end
    idle_all();
    check("p0_only_no_rvalid1", rvalid1, 0);

    c0 = 0; c1 = 0; n = 0; idles = 0; cyc = 0; g = '0;
    while ((c0 < 8 || c1 < 8) && cyc < 40) begin
      req0 = c0 < 8; we0 = 1'b1; addr0 = 16'(16'h40 + c0); wdata0 = 16'(16'h1000 + c0);
      req1 = c1 < 8; we1 = 1'b1; addr1 = 16'(16'h50 + c1); wdata1 = 16'(16'h2000 + c1);
      @(negedge clk);
      check("burst_not_both", 32'(ack0 & ack1), 0);
      if (ack0 | ack1) begin
        if (n < 16) g[n] = ack1;
        n++;
        c0 += 32'(ack0);
        c1 += 32'(ack1);
      end else if (n > 0) idles++;
      @(posedge clk); #1;
      cyc++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("burst_beats", n, 16);
`ifdef ARB_ROUND_ROBIN_EN
    pat = 16'hF0F0;
    check("burst_idles", idles, 0);
`else
    pat = 16'hFF00;
    check("burst_idles", idles, 1);
`endif
    for (int k = 0; k < 16; k++) check($sformatf("burst_grant%0d", k), g[k], pat[k]);
    idle_all();
    for (int i = 0; i < 8; i++) begin
      beat(1, 1'b0, 16'(16'h50 + i), 16'h0);
      check("rd1_p1_data", rdata1, 32'(16'h2000 + i));
      check("rd1_valid", rvalid1, 1);
    end
    for (int i = 0; i < 8; i++) begin
      beat(1, 1'b0, 16'(16'h40 + i), 16'h0);
      check("rd1_p0_data", rdata1, 32'(16'h1000 + i));
    end
    idle_all();

`ifndef ARB_ROUND_ROBIN_EN
    req0 = 1'b1; we0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 16'd5;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 30) begin
      addr0 = 16'(16'h80 + n); wdata0 = 16'(n);
      @(negedge clk);
      check("fp_ack1_low", ack1, 0);
      if (ack0) n++;
      @(posedge clk); #1;
      cyc++;
    end
    check("fp_p0_beats", n, 10);
    req0 = 1'b0;
    @(negedge clk);
    check("fp_drop_ack0", ack0, 0);
    check("fp_drop_ack1", ack1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fp_ack1_rise", ack1, 1);
    @(posedge clk); #1;
    check("fp_rd1_valid", rvalid1, 1);
    check("fp_rd1_data", rdata1, 16'h0005);
    idle_all();
`endif

    beat(1, 1'b1, 16'h60, 16'hAAAA);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h61; wdata0 = 16'h1234;
    we1 = 1'b0; addr1 = 16'd5;
    @(negedge clk);
    check("drop_last_ack1", ack1, 1);
    check("drop_last_ack0", ack0, 0);
    @(posedge clk); #1 req1 = 1'b0;
    #1 check("drop_ack1_falls", ack1, 0);
    @(negedge clk);
    check("drop_ack0_wait", ack0, 0);
    check("drop_rvalid1", rvalid1, 1);
    check("drop_rdata1", rdata1, 16'h0005);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_ack0_rise", ack0, 1);
    @(posedge clk); #1;
    idle_all();

    beat(1, 1'b1, 16'h62, 16'h0001);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h63; wdata0 = 16'h0002;
    pre = 6'b001111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("preempt_ack1_%0d", k), ack1, pre[k]);
      check($sformatf("preempt_ack0_%0d", k), ack0, !pre[k]);
      @(posedge clk); #1;
    end
    idle_all();

    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd7; wdata0 = 16'hBEEF;
    n = 0;
    @(negedge clk);
    while (!ack0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_ack0_seen", ack0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_mem_write", mem_write, 0);
    check("rstmid_mem_read", mem_read, 0);
    check("rstmid_ack0", ack0, 0);
    check("rstmid_mem_addr", mem_address, 0);
    req0 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_rvalid0", rvalid0, 0);
    check("rstmid_rvalid1", rvalid1, 0);
    check("rstmid_rdata0", rdata0, 0);
    check("rstmid_rdata1", rdata1, 0);
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    check("rstmid_idle_acks", {ack0, ack1}, 0);
    @(negedge clk);
    check("rstmid_tie_ack0", ack0, 1);
    check("rstmid_tie_ack1", ack1, 0);
    @(posedge clk); #1;
    idle_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
